// File: rtl/alu.sv
// 8-bit registered ALU for the execute stage: 16 unsigned operations on A/B,
// result and add-carry registered together for a fixed one-cycle latency.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ROL  = 4'h6, OP_ROR  = 4'h7,
    OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
    OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF
  } alu_op_e;

  logic [WIDTH-1:0] result_next;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] rol_a;
  logic [WIDTH-1:0] ror_a;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] alu_out_reg;
  logic             carry_reg;

  assign sum_full = {1'b0, A} + {1'b0, B};

  // Rotations are pure wiring: each result bit picks its neighbour of A.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rol_a[gi] = A[(gi + WIDTH - 1) % WIDTH];
      assign ror_a[gi] = A[(gi + 1) % WIDTH];
    end
  endgenerate

  // Divide-by-zero saturates to all ones instead of relying on X semantics.
  assign quot = (B == '0) ? {WIDTH{1'b1}} : (A / B);

  always_comb begin
    result_next = '0;
    case (ALU_Sel)
      OP_ADD:  result_next = sum_full[WIDTH-1:0];
      OP_SUB:  result_next = A - B;
      OP_MUL:  result_next = A * B;
      OP_DIV:  result_next = quot;
      OP_SHL:  result_next = {A[WIDTH-2:0], 1'b0};
      OP_SHR:  result_next = {1'b0, A[WIDTH-1:1]};
      OP_ROL:  result_next = rol_a;
      OP_ROR:  result_next = ror_a;
      OP_AND:  result_next = A & B;
      OP_OR:   result_next = A | B;
      OP_XOR:  result_next = A ^ B;
      OP_NOR:  result_next = ~(A | B);
      OP_NAND: result_next = ~(A & B);
      OP_XNOR: result_next = ~(A ^ B);
      OP_GT:   result_next = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   result_next = {{(WIDTH-1){1'b0}}, (A == B)};
      default: result_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_reg <= '0;
      carry_reg   <= 1'b0;
    end else begin
      alu_out_reg <= result_next;
      carry_reg   <= sum_full[WIDTH];
    end
  end

  assign ALU_Out  = alu_out_reg;
  assign CarryOut = carry_reg;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: reset, full op sweep, carry/wrap,
// boundary cases and back-to-back issue with hand-computed expectations.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  int pass_count = 0;
  int check_count = 0;

  alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  // Drive at negedge, sample #1 after the following posedge: one op per clock.
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic [3:0] sel, input logic [7:0] exp_out, input logic exp_c);
    @(negedge clk);
    A = a; B = b; ALU_Sel = sel;
    @(posedge clk);
    #1;
    check8({tag, "_out"}, ALU_Out, exp_out);
    check1({tag, "_c"}, CarryOut, exp_c);
    $display("op %s A=%02h B=%02h sel=%h -> out=%02h c=%0b", tag, a, b, sel, ALU_Out, CarryOut);
  endtask

  logic [7:0] sweep_exp [16];
  logic [7:0] bb_exp;

  initial begin
    sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

    // Reset held across edges with inputs that would otherwise carry.
    rst_n = 1'b0; A = 8'hFF; B = 8'hFF; ALU_Sel = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check8("rst_hold_out", ALU_Out, 8'h00);
    check1("rst_hold_c", CarryOut, 1'b0);
    $display("reset held: out=%02h c=%0b", ALU_Out, CarryOut);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      op($sformatf("sweep%h", i), 8'h0A, 8'h02, 4'(i), sweep_exp[i], 1'b0);

    op("cw_add", 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1);
    op("cw_sub", 8'hF6, 8'h0A, 4'h1, 8'hEC, 1'b1);
    op("cw_rol", 8'hF6, 8'h0A, 4'h6, 8'hED, 1'b1);
    op("cw_ror", 8'hF6, 8'h0A, 4'h7, 8'h7B, 1'b1);
    op("cw_mul", 8'hF6, 8'h0A, 4'h2, 8'h9C, 1'b1);

    op("div0",   8'h05, 8'h00, 4'h3, 8'hFF, 1'b0);
    op("subwrap",8'h00, 8'h01, 4'h1, 8'hFF, 1'b0);
    op("eq80",   8'h80, 8'h80, 4'hF, 8'h01, 1'b1);
    op("gt80",   8'h80, 8'h80, 4'hE, 8'h00, 1'b1);
    op("shl80",  8'h80, 8'h80, 4'h4, 8'h00, 1'b1);

    // Back-to-back: verify each result and that it holds until the next edge.
    for (int i = 0; i < 6; i++) begin
      bb_exp = (i % 2 == 0) ? 8'h30 : 8'hFC;
      op($sformatf("b2b%0d", i), 8'hF0, 8'h3C, (i % 2 == 0) ? 4'h8 : 4'h9, bb_exp, 1'b1);
      #3;
      check8($sformatf("b2b%0d_hold", i), ALU_Out, bb_exp);
    end

    // Asynchronous reset between edges clears the outputs without a clock.
    op("pre_rst", 8'h0A, 8'h02, 4'h0, 8'h0C, 1'b0);
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; ALU_Sel = 4'h0;
    #1;
    check8("async_pre_out", ALU_Out, 8'h0C);
    rst_n = 1'b0;
    #1;
    check8("async_rst_out", ALU_Out, 8'h00);
    check1("async_rst_c", CarryOut, 1'b0);
    $display("async reset: out=%02h c=%0b", ALU_Out, CarryOut);
    @(posedge clk);
    #1;
    check8("async_edge_out", ALU_Out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", 8'hF0, 8'h3C, 4'hA, 8'hCC, 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
